// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memOp encodings,
// arbiter state encoding and the op legality check.
package dmem_pkg;

  // Load encodings
  localparam logic [2:0] M_LB  = 3'd0;
  localparam logic [2:0] M_LH  = 3'd1;
  localparam logic [2:0] M_LW  = 3'd2;
  localparam logic [2:0] M_LBU = 3'd4;
  localparam logic [2:0] M_LHU = 3'd5;

  // Store aliases share the signed-load encodings
  localparam logic [2:0] M_SB = M_LB;
  localparam logic [2:0] M_SH = M_LH;
  localparam logic [2:0] M_SW = M_LW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Stores accept byte/half/word only; loads additionally accept unsigned forms.
  function automatic logic op_legal(input logic [2:0] op, input logic we);
    logic ok;
    ok = 1'b0;
    if (we) begin
      ok = (op == M_SB) || (op == M_SH) || (op == M_SW);
    end else begin
      ok = (op == M_LB) || (op == M_LH) || (op == M_LW) ||
           (op == M_LBU) || (op == M_LHU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: per-port request fields
// plus the shared response.
interface dmem_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] we;
  logic [AW-1:0]   addr  [NREQ];
  logic [DW-1:0]   wdata [NREQ];
  logic [2:0]      op    [NREQ];
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rvalid;
  logic [DW-1:0]   rdata;
  logic            rerr;

  modport master (
    output req, we, addr, wdata, op,
    input  gnt, rvalid, rdata, rerr
  );

  modport slave (
    input  req, we, addr, wdata, op,
    output gnt, rvalid, rdata, rerr
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner pick: scans requesters starting at ptr and returns
// the first asserted one as a one-hot vector (zero when nobody requests).
// The wrap of ptr+k relies on NREQ being a power of two.
module dmem_arb_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);

  logic [PW-1:0] idx;

  // First asserted request at or after ptr wins
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + PW'(k);
      if (win == '0 && req[idx]) begin
        win[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and single-access sequencer for the data memory.
// IDLE/RESP arbitrate, ACCESS holds the latched request on the mem_* registers
// for one memory edge, RESP returns data or acknowledge to the owner.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration; when undefined,
// port 0 has fixed priority and no pointer register exists.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic [2:0]    mem_op,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  logic [1:0]      state;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win;
  logic            arb_slot;
  logic            lat_we;
  logic            lat_legal;

  assign arb_slot = (state == ST_IDLE) || (state == ST_RESP);

  dmem_arb_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .win(win)
  );

  // Grant is only offered in an arbitration slot and never while reset is held
  assign bus.gnt = (arb_slot && rst_n) ? win : '0;

  // Encode the one-hot winner to a port index
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer: the port after the latest winner gets priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (arb_slot && (|win)) begin
      ptr <= win_idx + 1'b1;
    end
  end
`else
  // Fixed priority: scanning always starts at port 0
  assign ptr = '0;
`endif

  // Sequencer FSM and request latch onto the registered memory inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      lat_we    <= 1'b0;
      lat_legal <= 1'b1;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_op    <= M_LW;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (|win) begin
            mem_addr  <= bus.addr[win_idx];
            mem_din   <= bus.wdata[win_idx];
            mem_op    <= bus.op[win_idx];
            mem_we    <= bus.we[win_idx] && op_legal(bus.op[win_idx], bus.we[win_idx]);
            lat_we    <= bus.we[win_idx];
            lat_legal <= op_legal(bus.op[win_idx], bus.we[win_idx]);
            owner     <= win_idx;
            state     <= ST_ACCESS;
          end else begin
            mem_we <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // Write completes on this edge; the memory is idle during RESP
          mem_we <= 1'b0;
          state  <= ST_RESP;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Response mux: only active in RESP, stores and illegal ops return zero data
  always_comb begin
    bus.rvalid = '0;
    bus.rdata  = '0;
    bus.rerr   = 1'b0;
    if (state == ST_RESP) begin
      bus.rvalid[owner] = 1'b1;
      bus.rerr          = !lat_legal;
      bus.rdata         = (lat_we || !lat_legal) ? '0 : mem_dout;
    end
  end

endmodule
